sobel_window_gen: RTL and testbench
===================================

SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter ROWS, default 170, frame height (>=2).
REQ-003 SHALL have parameter COLS, default 113, frame width (>=3).
REQ-004 SHALL have parameter CNT_W, default 10, row/column counter width (2^CNT_W > max(ROWS,COLS)).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 in_valid_i  in  1  input column valid.
REQ-008 in_ready_o  out  1  block accepts a column this cycle.
REQ-009 d_top_i, d_mid_i, d_bot_i  in  DATA_W each  pixels of rows r-1, r, r+1 at one column.
REQ-010 sof_i  in  1  sideband marking the accepted column as row 0, col 0.
REQ-011 border_mode_i  in  1  0 = zero pad, 1 = replicate; sampled at the row-0 col-0 accept.
REQ-012 out_valid_o  out  1  window valid.
REQ-013 out_ready_i  in  1  downstream accepts window.
REQ-014 win_o  out  9*DATA_W  3x3 window w0..w8 row-major; w0 (top-left) in LSBs, w4 = centre.
REQ-015 eol_o, eof_o  out  1 each  window is last of row / last of frame.

Function
REQ-016 Transfer occurs when valid and ready are both 1 on a rising edge; no other condition transfers data.
REQ-017 in_ready_o SHALL be (!out_valid_o || out_ready_i) && state != FLUSH.
REQ-018 States: PRIME (col 0 of a row accepted, no output), RUN, FLUSH; reset state PRIME with column count 0.
REQ-019 Accepting col 0 SHALL load the 3-column shift register and stay in PRIME; no window is produced.
REQ-020 Accepting col c (1..COLS-1) SHALL, next cycle, present the window centred at col c-1 with out_valid_o=1.
REQ-021 After the window for centre COLS-2 transfers, state SHALL go to FLUSH and emit centre COLS-1 with the right column padded, eol_o=1, then return to PRIME.
REQ-022 Padding: col 0 centre pads left column; row 0 pads top row (d_top_i ignored); row ROWS-1 pads bottom row (d_bot_i ignored); corners pad both.
REQ-023 Zero mode: padded taps = 0. Replicate mode: padded taps take the nearest unpadded tap (left/right pad = centre column, top/bottom pad = middle row, corner = w4).
REQ-024 win_o, eol_o, eof_o SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-025 Row counter SHALL increment after each FLUSH transfer and wrap to 0 after ROWS-1; eof_o=1 only on the FLUSH window of row ROWS-1.
REQ-026 Accepting a column with sof_i=1 SHALL force row=0, col=0, discard any partial row without output, and resample border_mode_i.
REQ-027 Each row SHALL yield exactly COLS windows; each frame ROWS*COLS windows.
REQ-028 Sustained throughput SHALL be one window per cycle in RUN with out_ready_i=1, one bubble per row (FLUSH).

Reset
REQ-029 While rst=0: out_valid_o=0, win_o=0, eol_o=0, eof_o=0, in_ready_o=0, counters 0, shift register 0, state PRIME, latched border mode 0.
REQ-030 Reset mid-frame SHALL drop any pending window; first column accepted after release is row 0, col 0.

Configuration
REQ-031 Macro SOBEL_WIN_REPLICATE_EN: defined -> both border modes per REQ-023; undefined -> replicate logic absent, border_mode_i ignored, zero padding always.

Verification
REQ-032 ROWS=3 COLS=4 zero mode, columns pixel=10*r+c, out_ready_i=1 -> 12 windows; row0 col0 win = {0,0,0,0,0,1,0,10,11}; eol_o on 4th, eof_o on 12th only.
REQ-033 Same frame, border_mode_i=1 -> row0 col0 win = {0,0,1,0,0,1,10,10,11}; row2 col3 win = {12,13,13,22,23,23,22,23,23}.
REQ-034 out_ready_i low for 5 cycles mid-row -> in_ready_o=0, win_o unchanged, no window lost or duplicated.
REQ-035 sof_i=1 on col 2 of row 1 -> no output for discarded row; next windows report row 0 borders.
REQ-036 rst=0 for one cycle during FLUSH -> out_valid_o=0 next cycle, next frame windows correct from col 0.
REQ-037 Build without SOBEL_WIN_REPLICATE_EN, border_mode_i=1 -> outputs identical to REQ-032.

Source files
------------

// File: rtl/sobel_window_gen.sv
// 3x3 Sobel window generator over column-serial input with border padding (SOBEL_WIN_REPLICATE_EN adds replicate mode).
// Latency: window centred at col c-1 appears the cycle after col c is accepted; one flush bubble per row.
// Backpressure: registered output stage; input stalls while a window is held or the row is flushing.
module sobel_window_gen #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 170,
    parameter int COLS   = 113,
    parameter int CNT_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_W-1:0]     d_top_i,
    input  logic [DATA_W-1:0]     d_mid_i,
    input  logic [DATA_W-1:0]     d_bot_i,
    input  logic                  sof_i,
    input  logic                  border_mode_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [9*DATA_W-1:0]   win_o,
    output logic                  eol_o,
    output logic                  eof_o
);

    typedef enum logic [1:0] {PRIME, RUN, FLUSH} state_t;

    localparam logic [CNT_W-1:0] COLS_C   = CNT_W'(COLS);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t                state, state_n;
    logic [CNT_W-1:0]      col, col_n;
    logic [CNT_W-1:0]      row, row_n;
    logic [3*DATA_W-1:0]   sr0, sr1, sr2;
    logic [3*DATA_W-1:0]   sr0_n, sr1_n, sr2_n;
    logic [3*DATA_W-1:0]   in_col;
    logic                  vld, vld_n;
    logic [9*DATA_W-1:0]   win, win_n;
    logic                  eol, eol_n;
    logic                  eof, eof_n;
    logic                  rep;
    logic                  acc;
    logic                  xfer;

    // Columns are packed {bot, mid, top}: tap row i lives at slice i.
    function automatic logic [9*DATA_W-1:0] make_win(
        input logic [3*DATA_W-1:0] l,
        input logic [3*DATA_W-1:0] c,
        input logic [3*DATA_W-1:0] r,
        input logic                pl,
        input logic                pr,
        input logic                pt,
        input logic                pb,
        input logic                rp
    );
        logic [DATA_W-1:0]   h [3][3];
        logic [DATA_W-1:0]   w [3][3];
        logic [9*DATA_W-1:0] res;
        for (int i = 0; i < 3; i++) begin
            h[i][0] = pl ? (rp ? c[i*DATA_W +: DATA_W] : '0) : l[i*DATA_W +: DATA_W];
            h[i][1] = c[i*DATA_W +: DATA_W];
            h[i][2] = pr ? (rp ? c[i*DATA_W +: DATA_W] : '0) : r[i*DATA_W +: DATA_W];
        end
        // Vertical padding copies the already horizontally padded middle row, so corners become w4.
        for (int j = 0; j < 3; j++) begin
            w[0][j] = pt ? (rp ? h[1][j] : '0) : h[0][j];
            w[1][j] = h[1][j];
            w[2][j] = pb ? (rp ? h[1][j] : '0) : h[2][j];
        end
        res = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                res[(3*i+j)*DATA_W +: DATA_W] = w[i][j];
            end
        end
        return res;
    endfunction

`ifdef SOBEL_WIN_REPLICATE_EN
    logic border, border_n;
    assign rep = border;
`else
    logic unused_border;
    assign unused_border = border_mode_i;
    assign rep = 1'b0;
`endif

    assign in_col      = {d_bot_i, d_mid_i, d_top_i};
    assign out_valid_o = rst & vld;
    assign win_o       = rst ? win : '0;
    assign eol_o       = rst & eol;
    assign eof_o       = rst & eof;
    assign in_ready_o  = rst && (!out_valid_o || out_ready_i) && (state != FLUSH);
    assign acc         = in_valid_i & in_ready_o;
    assign xfer        = out_valid_o & out_ready_i;

    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row;
        sr0_n   = sr0;
        sr1_n   = sr1;
        sr2_n   = sr2;
        vld_n   = vld & ~xfer;
        win_n   = win;
        eol_n   = eol;
        eof_n   = eof;
`ifdef SOBEL_WIN_REPLICATE_EN
        border_n = border;
`endif
        case (state)
            FLUSH: begin
                if (xfer) begin
                    state_n = PRIME;
                    row_n   = (row == LAST_ROW) ? '0 : row + ONE;
                end
            end
            default: begin
                if (state == RUN && col == COLS_C && xfer) begin
                    state_n = FLUSH;
                    vld_n   = 1'b1;
                    win_n   = make_win(sr1, sr2, '0, 1'b0, 1'b1,
                                       row == '0, row == LAST_ROW, rep);
                    eol_n   = 1'b1;
                    eof_n   = (row == LAST_ROW);
                end
                if (acc) begin
                    sr0_n = sr1;
                    sr1_n = sr2;
                    sr2_n = in_col;
                    if (sof_i) begin
                        state_n = PRIME;
                        col_n   = ONE;
                        row_n   = '0;
                        vld_n   = 1'b0;
                        eol_n   = 1'b0;
                        eof_n   = 1'b0;
`ifdef SOBEL_WIN_REPLICATE_EN
                        border_n = border_mode_i;
`endif
                    end else if (col == COLS_C) begin
                        // Col 0 of the next row, accepted while the last RUN window leaves.
                        col_n = ONE;
`ifdef SOBEL_WIN_REPLICATE_EN
                        if (row == LAST_ROW) border_n = border_mode_i;
`endif
                    end else if (col == '0) begin
                        col_n = ONE;
`ifdef SOBEL_WIN_REPLICATE_EN
                        if (row == '0) border_n = border_mode_i;
`endif
                    end else begin
                        col_n   = col + ONE;
                        state_n = RUN;
                        vld_n   = 1'b1;
                        win_n   = make_win(sr1, sr2, in_col, col == ONE, 1'b0,
                                           row == '0, row == LAST_ROW, rep);
                        eol_n   = 1'b0;
                        eof_n   = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= PRIME;
            col   <= '0;
            row   <= '0;
            sr0   <= '0;
            sr1   <= '0;
            sr2   <= '0;
            vld   <= 1'b0;
            win   <= '0;
            eol   <= 1'b0;
            eof   <= 1'b0;
        end else begin
            state <= state_n;
            col   <= col_n;
            row   <= row_n;
            sr0   <= sr0_n;
            sr1   <= sr1_n;
            sr2   <= sr2_n;
            vld   <= vld_n;
            win   <= win_n;
            eol   <= eol_n;
            eof   <= eof_n;
        end
    end

`ifdef SOBEL_WIN_REPLICATE_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            border <= 1'b0;
        end else begin
            border <= border_n;
        end
    end
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 3x4 frame with pixel = 10*row + col.
module tb_sobel_window_gen;

    localparam int DW = 8;
    localparam int R  = 3;
    localparam int C  = 4;
    localparam int CW = 10;
`ifdef SOBEL_WIN_REPLICATE_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   d_top = '0;
    logic [DW-1:0]   d_mid = '0;
    logic [DW-1:0]   d_bot = '0;
    logic            sof = 1'b0;
    logic            border = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [9*DW-1:0] win;
    logic            eol;
    logic            eof;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [9*DW-1:0] w;
        logic            eol;
        logic            eof;
        int              cyc;
    } rec_t;
    rec_t q[$];

    sobel_window_gen #(.DATA_W(DW), .ROWS(R), .COLS(C), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .d_top_i(d_top), .d_mid_i(d_mid), .d_bot_i(d_bot),
        .sof_i(sof), .border_mode_i(border),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .win_o(win), .eol_o(eol), .eof_o(eof)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rec_t t;
        if (rst && out_valid && out_ready) begin
            t.w = win; t.eol = eol; t.eof = eof; t.cyc = cyc;
            q.push_back(t);
        end
    end

    function automatic int pix(input int r, input int c);
        return 10 * r + c;
    endfunction

    // Replicate padding is coordinate clamping; zero padding uses 0 outside the frame.
    function automatic logic [9*DW-1:0] exp_win(input int r, input int c, input bit rp);
        logic [9*DW-1:0] res;
        res = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                int rr, cc, v;
                rr = r + dr - 1;
                cc = c + dc - 1;
                if (rr < 0 || rr >= R || cc < 0 || cc >= C) begin
                    if (rp) begin
                        rr = (rr < 0) ? 0 : ((rr >= R) ? R - 1 : rr);
                        cc = (cc < 0) ? 0 : ((cc >= C) ? C - 1 : cc);
                        v  = pix(rr, cc);
                    end else begin
                        v = 0;
                    end
                end else begin
                    v = pix(rr, cc);
                end
                res[(dr*3+dc)*DW +: DW] = DW'(v);
            end
        end
        return res;
    endfunction

    function automatic logic [9*DW-1:0] pack9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        return {DW'(a8), DW'(a7), DW'(a6), DW'(a5), DW'(a4), DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    endfunction

    task automatic send_col(input int idx, input bit s);
        int r, c;
        bit a;
        r = idx / C;
        c = idx % C;
        d_top    = (r == 0) ? 8'hEE : DW'(pix(r - 1, c));
        d_mid    = DW'(pix(r, c));
        d_bot    = (r == R - 1) ? 8'hDD : DW'(pix(r + 1, c));
        sof      = s;
        in_valid = 1'b1;
        a = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            a = in_ready;
            @(posedge clk);
            #1;
            if (a) break;
        end
        sof = 1'b0;
        if (!a) begin
            $display("FAIL send_col timeout idx=%0d: in_ready never 1 within 500 cycles", idx);
            $fatal(1, "stalled");
        end
    endtask

    task automatic send_range(input int first, input int last, input bit s_first);
        for (int i = first; i <= last; i++) send_col(i, s_first && (i == first));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        n_tests++; if (win !== '0) begin n_fail++; $display("FAIL reset_win got=%h want=0", win); end
        n_tests++; if ({eol, eof} !== 2'b00) begin n_fail++; $display("FAIL reset_eol_eof got=%b want=00", {eol, eof}); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_zero_frame();
        q.delete();
        border = 1'b0;
        send_range(0, R * C - 1, 1'b1);
        drain();
        n_tests++; if (q.size() != R * C) begin n_fail++; $display("FAIL zero_count got=%0d want=%0d", q.size(), R * C); end
        for (int i = 0; i < q.size() && i < R * C; i++) begin
            n_tests++;
            if (q[i].w !== exp_win(i / C, i % C, 1'b0) || q[i].eol !== (i % C == C - 1) || q[i].eof !== (i == R * C - 1)) begin
                n_fail++;
                $display("FAIL zero_win[%0d] got=%h eol=%b eof=%b want=%h eol=%b eof=%b", i, q[i].w, q[i].eol, q[i].eof,
                         exp_win(i / C, i % C, 1'b0), (i % C == C - 1), (i == R * C - 1));
            end
        end
        if (q.size() == R * C) begin
            n_tests++;
            if (q[0].w !== pack9(0, 0, 0, 0, 0, 1, 0, 10, 11)) begin
                n_fail++; $display("FAIL zero_r0c0 got=%h want=%h", q[0].w, pack9(0, 0, 0, 0, 0, 1, 0, 10, 11));
            end
            n_tests++;
            if (q[R * C - 1].cyc - q[0].cyc != R * C + R - 2) begin
                n_fail++; $display("FAIL throughput_span got=%0d want=%0d", q[R * C - 1].cyc - q[0].cyc, R * C + R - 2);
            end
        end
    endtask

    task automatic test_replicate();
        logic [9*DW-1:0] w00, w23;
        q.delete();
        border = 1'b1;
        send_col(0, 1'b1);
        border = 1'b0;
        for (int i = 1; i < R * C; i++) send_col(i, 1'b0);
        in_valid = 1'b0;
        drain();
        w00 = REP ? pack9(0, 0, 1, 0, 0, 1, 10, 10, 11) : pack9(0, 0, 0, 0, 0, 1, 0, 10, 11);
        w23 = REP ? pack9(12, 13, 13, 22, 23, 23, 22, 23, 23) : pack9(12, 13, 0, 22, 23, 0, 0, 0, 0);
        n_tests++; if (q.size() != R * C) begin n_fail++; $display("FAIL rep_count got=%0d want=%0d", q.size(), R * C); end
        for (int i = 0; i < q.size() && i < R * C; i++) begin
            n_tests++;
            if (q[i].w !== exp_win(i / C, i % C, REP)) begin
                n_fail++; $display("FAIL rep_win[%0d] got=%h want=%h", i, q[i].w, exp_win(i / C, i % C, REP));
            end
        end
        if (q.size() == R * C) begin
            n_tests++; if (q[0].w !== w00) begin n_fail++; $display("FAIL rep_r0c0 got=%h want=%h", q[0].w, w00); end
            n_tests++; if (q[R * C - 1].w !== w23) begin n_fail++; $display("FAIL rep_r2c3 got=%h want=%h", q[R * C - 1].w, w23); end
        end
    endtask

    task automatic test_backpressure();
        q.delete();
        fork
            send_range(0, R * C - 1, 1'b0);
            begin
                for (int k = 0; k < 300; k++) begin
                    @(posedge clk); #1;
                    if (q.size() >= 5) break;
                end
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d] got=%b want=0", k, in_ready); end
                    n_tests++;
                    if (out_valid !== 1'b1 || win !== exp_win(1, 1, 1'b0)) begin
                        n_fail++; $display("FAIL stall_hold[%0d] got vld=%b win=%h want vld=1 win=%h", k, out_valid, win, exp_win(1, 1, 1'b0));
                    end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        n_tests++; if (q.size() != R * C) begin n_fail++; $display("FAIL bp_count got=%0d want=%0d", q.size(), R * C); end
        for (int i = 0; i < q.size() && i < R * C; i++) begin
            n_tests++;
            if (q[i].w !== exp_win(i / C, i % C, 1'b0) || q[i].eol !== (i % C == C - 1)) begin
                n_fail++; $display("FAIL bp_win[%0d] got=%h eol=%b want=%h eol=%b", i, q[i].w, q[i].eol, exp_win(i / C, i % C, 1'b0), (i % C == C - 1));
            end
        end
    endtask

    task automatic test_sof_restart();
        int j;
        q.delete();
        send_range(0, C + 1, 1'b0);
        send_range(0, R * C - 1, 1'b1);
        drain();
        n_tests++; if (q.size() != C + 1 + R * C) begin n_fail++; $display("FAIL sof_count got=%0d want=%0d", q.size(), C + 1 + R * C); end
        for (int i = 0; i < q.size() && i < C + 1 + R * C; i++) begin
            j = (i <= C) ? i : i - C - 1;
            n_tests++;
            if (q[i].w !== exp_win(j / C, j % C, 1'b0) || q[i].eol !== (j % C == C - 1) || q[i].eof !== (i == C + R * C)) begin
                n_fail++; $display("FAIL sof_win[%0d] got=%h eol=%b eof=%b want=%h eol=%b eof=%b", i, q[i].w, q[i].eol, q[i].eof,
                                   exp_win(j / C, j % C, 1'b0), (j % C == C - 1), (i == C + R * C));
            end
        end
    endtask

    task automatic test_reset_flush();
        q.delete();
        send_range(0, C - 1, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        n_tests++; if ({out_valid, eol} !== 2'b11) begin n_fail++; $display("FAIL flush_pending got vld,eol=%b want=11", {out_valid, eol}); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_low_valid got=%b want=0", out_valid); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_after_valid got=%b want=0", out_valid); end
        out_ready = 1'b1;
        drain();
        n_tests++; if (q.size() != C - 1) begin n_fail++; $display("FAIL rst_dropped_count got=%0d want=%0d", q.size(), C - 1); end
        q.delete();
        send_range(0, R * C - 1, 1'b0);
        drain();
        n_tests++; if (q.size() != R * C) begin n_fail++; $display("FAIL rst_frame_count got=%0d want=%0d", q.size(), R * C); end
        for (int i = 0; i < q.size() && i < R * C; i++) begin
            n_tests++;
            if (q[i].w !== exp_win(i / C, i % C, 1'b0) || q[i].eof !== (i == R * C - 1)) begin
                n_fail++; $display("FAIL rst_frame_win[%0d] got=%h eof=%b want=%h eof=%b", i, q[i].w, q[i].eof, exp_win(i / C, i % C, 1'b0), (i == R * C - 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_replicate();
        test_backpressure();
        test_sof_restart();
        test_reset_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
